// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder behind the core's DM_CS/DM_W/DM_R strobes. Each
//   accepted request performs one 32-bit word load or store after
//   WAIT_CYCLES wait states. While the access is pending, stall holds the
//   PC and register file. Malformed requests (misaligned address, or both
//   W and R set) are rejected with an err pulse and never touch memory.
//
// Parameters
//   ADDR_WIDTH  : word-address bits; the array holds 2**ADDR_WIDTH words
//   WAIT_CYCLES : wait states before an access completes (0..15)
//
// Ports
//   clk, rst    : clock; synchronous active-high reset
//   DM_CS       : request strobe, held by the core while stall=1
//   DM_W, DM_R  : store / load select
//   addr, wdata : byte address and store data
//   rdata       : registered load data, held until the next load completes
//   ready       : one-cycle completion pulse
//   stall       : core must not advance this cycle
//   err         : one-cycle pulse, request rejected
module dmem_responder #(
    parameter int ADDR_WIDTH  = 11,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_CS,
    input  logic        DM_W,
    input  logic        DM_R,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  w_q;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic                  valid_req;
    logic [ADDR_WIDTH-1:0] idx_in;
    logic                  acc_fire;
    logic                  acc_w;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_wdata;

    // Upper address bits are deliberately ignored so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    assign valid_req = DM_CS & (DM_W ^ DM_R) & (addr[1:0] == 2'b00);
    assign idx_in    = addr[ADDR_WIDTH+1:2];

    assign stall = !rst && ((state == IDLE && valid_req) || state == BUSY);

    // Access select. Normally the latched request fires out of BUSY; with
    // zero wait states the access happens on the accepting edge itself, so
    // the live inputs are used instead of the request registers.
    always_comb begin
        acc_fire  = 1'b0;
        acc_w     = w_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        if (!rst) begin
            if (state == BUSY && DM_CS && cnt == 4'd0) begin
                acc_fire = 1'b1;
            end else if (WAIT_CYCLES == 0 && state == IDLE && valid_req) begin
                acc_fire  = 1'b1;
                acc_w     = DM_W;
                acc_idx   = idx_in;
                acc_wdata = wdata;
            end
        end
    end

    // Memory array is not reset; writes are suppressed during reset by acc_fire.
    always_ff @(posedge clk) begin
        if (acc_fire && acc_w)
            mem[acc_idx] <= acc_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            w_q     <= 1'b0;
            rdata   <= 32'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_req) begin
                        idx_q   <= idx_in;
                        wdata_q <= wdata;
                        w_q     <= DM_W;
                        cnt     <= CNT_INIT;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                            ready <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end else if (DM_CS) begin
                        err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!DM_CS) begin
                        state <= IDLE;          // abort, nothing written
                    end else if (cnt == 4'd0) begin
                        state <= DONE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: state <= IDLE;            // forces one IDLE gap between requests
                default: state <= IDLE;
            endcase
            if (acc_fire && !acc_w)
                rdata <= mem[acc_idx];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cs, wr, re;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rdat [2];
    logic [1:0]  rdy, stl, er;

    int vec  = 0;
    int miss = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    // index 0: zero-wait build, index 1: two wait states
    dmem_responder #(.ADDR_WIDTH(11), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .DM_CS(cs[0]), .DM_W(wr[0]), .DM_R(re[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rdat[0]), .ready(rdy[0]),
        .stall(stl[0]), .err(er[0]));

    dmem_responder #(.ADDR_WIDTH(11), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .DM_CS(cs[1]), .DM_W(wr[1]), .DM_R(re[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rdat[1]), .ready(rdy[1]),
        .stall(stl[1]), .err(er[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request on instance k. Checks stall for every wait cycle,
    // the ready pulse, the loaded data against the scoreboard, and that
    // ready drops again. Optionally alters addr/wdata one cycle after
    // acceptance to show only the latched copies are used.
    task automatic acc(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       input logic chg, input logic [31:0] a2, input logic [31:0] d2);
        int nw;
        nw = (k == 0) ? 0 : 2;
        cs[k] = 1'b1; wr[k] = w; re[k] = !w; ad[k] = a; wd[k] = d;
        if (!w) exp_q.push_back(exp_rd);
        for (int c = 0; c <= nw; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1 && chg) begin ad[k] = a2; wd[k] = d2; end
            #1;
            chk($sformatf("stall_c%0d_u%0d", c, k), 32'(stl[k]), 32'd1);
            chk($sformatf("noready_c%0d_u%0d", c, k), 32'(rdy[k]), 32'd0);
        end
        @(negedge clk); #1;
        chk($sformatf("ready_u%0d", k), 32'(rdy[k]), 32'd1);
        chk($sformatf("done_nostall_u%0d", k), 32'(stl[k]), 32'd0);
        chk($sformatf("done_noerr_u%0d", k), 32'(er[k]), 32'd0);
        if (!w) chk($sformatf("rdata_%h_u%0d", a, k), rdat[k], exp_q.pop_front());
        cs[k] = 1'b0;
        @(negedge clk); #1;
        chk($sformatf("ready_drop_u%0d", k), 32'(rdy[k]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cs = '0; wr = '0; re = '0;
        ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;

        // reset: stall must stay low even with a valid request present
        @(negedge clk);
        cs[1] = 1'b1; wr[1] = 1'b1; ad[1] = 32'h10;
        @(negedge clk); #1;
        chk("rst_stall", 32'(stl[1]), 32'd0);
        chk("rst_ready", 32'(rdy[1]), 32'd0);
        chk("rst_err",   32'(er[1]),  32'd0);
        chk("rst_rdata", rdat[1], 32'd0);
        chk("rst_rdata0", rdat[0], 32'd0);
        cs[1] = 1'b0; wr[1] = 1'b0;
        rst = 1'b0;
        @(negedge clk); #1;

        // store then load, two wait states
        acc(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, 32'h0);
        acc(1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);

        // malformed: misaligned store, then W and R together
        cs[1] = 1'b1; wr[1] = 1'b1; re[1] = 1'b0; ad[1] = 32'h12; wd[1] = 32'h0BAD_0BAD;
        #1;
        chk("bad_align_stall", 32'(stl[1]), 32'd0);
        chk("bad_align_err0", 32'(er[1]), 32'd0);
        @(negedge clk); #1;
        chk("bad_align_err", 32'(er[1]), 32'd1);
        chk("bad_align_ready", 32'(rdy[1]), 32'd0);
        wr[1] = 1'b1; re[1] = 1'b1; ad[1] = 32'h10;
        #1;
        chk("bad_wr_stall", 32'(stl[1]), 32'd0);
        @(negedge clk); #1;
        chk("bad_wr_err", 32'(er[1]), 32'd1);
        cs[1] = 1'b0; wr[1] = 1'b0; re[1] = 1'b0;
        @(negedge clk); #1;
        chk("bad_err_drop", 32'(er[1]), 32'd0);
        acc(1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);

        // abort: drop DM_CS during BUSY
        acc(1, 1'b1, 32'h20, 32'h1111_2222, 32'h0, 1'b0, 32'h0, 32'h0);
        cs[1] = 1'b1; wr[1] = 1'b1; re[1] = 1'b0; ad[1] = 32'h20; wd[1] = 32'h1234_5678;
        #1;
        chk("abort_stall0", 32'(stl[1]), 32'd1);
        @(negedge clk);
        cs[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("abort_noready_%0d", c), 32'(rdy[1]), 32'd0);
            chk($sformatf("abort_nostall_%0d", c), 32'(stl[1]), 32'd0);
        end
        acc(1, 1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0, 32'h0, 32'h0);

        // reset while BUSY on the access cycle
        cs[1] = 1'b1; wr[1] = 1'b1; re[1] = 1'b0; ad[1] = 32'h20; wd[1] = 32'h1234_5678;
        #1;
        chk("rbusy_stall0", 32'(stl[1]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rbusy_stall_in_rst", 32'(stl[1]), 32'd0);
        @(negedge clk); #1;
        chk("rbusy_ready", 32'(rdy[1]), 32'd0);
        chk("rbusy_err",   32'(er[1]),  32'd0);
        chk("rbusy_rdata", rdat[1], 32'd0);
        chk("rbusy_stall", 32'(stl[1]), 32'd0);
        rst = 1'b0; cs[1] = 1'b0; wr[1] = 1'b0;
        @(negedge clk); #1;
        acc(1, 1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0, 32'h0, 32'h0);

        // wrap-around: 0x2004 aliases 0x4 with an 11-bit word index
        acc(1, 1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 32'h0, 1'b0, 32'h0, 32'h0);
        acc(1, 1'b0, 32'h0000_0004, 32'h0, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'h0);

        // inputs changed after acceptance are ignored
        acc(1, 1'b1, 32'h34, 32'h5555_5555, 32'h0, 1'b0, 32'h0, 32'h0);
        acc(1, 1'b1, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b1, 32'h34, 32'h0BAD_0BAD);
        acc(1, 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0);
        acc(1, 1'b0, 32'h34, 32'h0, 32'h5555_5555, 1'b0, 32'h0, 32'h0);

        // zero-wait build: back-to-back stores then loads, read-after-write
        acc(0, 1'b1, 32'h0, 32'h0101_0101, 32'h0, 1'b0, 32'h0, 32'h0);
        acc(0, 1'b1, 32'h4, 32'h0202_0202, 32'h0, 1'b0, 32'h0, 32'h0);
        acc(0, 1'b0, 32'h0, 32'h0, 32'h0101_0101, 1'b0, 32'h0, 32'h0);
        acc(0, 1'b0, 32'h4, 32'h0, 32'h0202_0202, 1'b0, 32'h0, 32'h0);
        acc(0, 1'b1, 32'h4, 32'h0303_0303, 32'h0, 1'b0, 32'h0, 32'h0);
        acc(0, 1'b0, 32'h4, 32'h0, 32'h0303_0303, 1'b0, 32'h0, 32'h0);

        // zero-wait malformed request
        cs[0] = 1'b1; wr[0] = 1'b0; re[0] = 1'b1; ad[0] = 32'h1;
        #1;
        chk("z_bad_stall", 32'(stl[0]), 32'd0);
        @(negedge clk); #1;
        chk("z_bad_err", 32'(er[0]), 32'd1);
        chk("z_bad_ready", 32'(rdy[0]), 32'd0);
        cs[0] = 1'b0;
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
